updown_counter_driver: RTL

UPDOWN_COUNTER_DRIVER -- requirements
Module: updown_counter_driver

---
 rtl/updown_ctr_pkg.sv | 22 ++
 rtl/ctr_watchdog.sv | 31 +++
 rtl/updown_counter_driver.sv | 129 ++++++++++++
 3 files changed

// File: rtl/updown_ctr_pkg.sv
// rtl/updown_ctr_pkg.sv - shared encodings for the up/down counter driver
package updown_ctr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRESET = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [1:0] STATUS_EXPIRED = 2'd0;
    localparam logic [1:0] STATUS_TIMEOUT = 2'd1;
    localparam logic [1:0] STATUS_ABORTED = 2'd2;

    localparam logic UP = 1'b1;
    localparam logic DN = 1'b0;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ctr_watchdog.sv
// rtl/ctr_watchdog.sv - counts enabled cycles, flags the TIMEOUT_CYCLES-th one
module ctr_watchdog
    import updown_ctr_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic clk,
    input  logic resetb,
    input  logic clear,
    input  logic cnt_en,
    output logic terminal_count
);

    localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] count;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (cnt_en) begin
            count <= sat_inc16(count);
        end
    end

    // Asserted during the enabled cycle that completes the timeout window.
    assign terminal_count = cnt_en && (count == LAST);

endmodule

// File: rtl/updown_counter_driver.sv
// rtl/updown_counter_driver.sv - sequences preset/run/done of an external up/down counter
module updown_counter_driver
    import updown_ctr_pkg::*;
#(
    parameter int unsigned DEFAULT_PRESET = 200,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_dir,
    input  logic [7:0]  cmd_preset_value,
    input  logic        cmd_use_default,
    input  logic        pause_req,
    input  logic        abort,
    output logic        new_cntr_preset,
    output logic [7:0]  new_cntr_preset_value,
    output logic        enable_cnt_up,
    output logic        enable_cnt_dn,
    output logic        pause_counting,
    input  logic        ctr_expired,
    output logic        busy,
    output logic        done,
    output logic [1:0]  done_status,
    output logic [15:0] run_cycles
);

    localparam logic [7:0] DEFAULT_PRESET_B = 8'(DEFAULT_PRESET);

    state_t     state;
    state_t     state_next;
    logic [1:0] status_next;
    logic       dir;
    logic       accept;
    logic       wd_clear;
    logic       wd_en;
    logic       wd_terminal;

    assign cmd_ready = (state == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign wd_en     = (state == ST_RUN) && !pause_counting;
    assign wd_clear  = (state != ST_RUN);

    ctr_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk           (clk),
        .resetb        (resetb),
        .clear         (wd_clear),
        .cnt_en        (wd_en),
        .terminal_count(wd_terminal)
    );

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        status_next = done_status;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_PRESET;
                end
            end
            ST_PRESET: begin
                if (abort) begin
                    state_next  = ST_DONE;
                    status_next = STATUS_ABORTED;
                end else begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_next  = ST_DONE;
                    status_next = STATUS_ABORTED;
                end else if (ctr_expired) begin
                    state_next  = ST_DONE;
                    status_next = STATUS_EXPIRED;
                end else if (wd_terminal) begin
                    state_next  = ST_DONE;
                    status_next = STATUS_TIMEOUT;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            dir                   <= DN;
            new_cntr_preset       <= 1'b0;
            new_cntr_preset_value <= '0;
            enable_cnt_up         <= 1'b0;
            enable_cnt_dn         <= 1'b0;
            pause_counting        <= 1'b0;
            busy                  <= 1'b0;
            done                  <= 1'b0;
            done_status           <= STATUS_EXPIRED;
            run_cycles            <= '0;
        end else begin
            new_cntr_preset <= (state_next == ST_PRESET);
            enable_cnt_up   <= (state_next == ST_RUN) && (dir == UP);
            enable_cnt_dn   <= (state_next == ST_RUN) && (dir == DN);
            pause_counting  <= pause_req && (state_next == ST_RUN);
            busy            <= (state_next != ST_IDLE);
            done            <= (state_next == ST_DONE);
            done_status     <= status_next;
            if (accept) begin
                dir                   <= cmd_dir;
                new_cntr_preset_value <= cmd_use_default ? DEFAULT_PRESET_B : cmd_preset_value;
                run_cycles            <= '0;
            end else if (wd_en) begin
                run_cycles <= sat_inc16(run_cycles);
            end
        end
    end

endmodule
